// File: rtl/alu_pipe_p.sv
// Two-stage pipelined N-bit ALU with valid/ready handshakes on input and output.
// Optional accumulator operand source is compiled in with `define ALU_ACC_EN.
module alu_pipe_p #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   OP,
    input  logic         in_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic [3:0]   FLAGS
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SLT  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    logic         s1_valid;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    op_t          s1_op;
    logic         adv1;
    logic         adv2;
    logic [N-1:0] bop;
    logic [N:0]   sum;
    logic [N:0]   dif;
    logic         lt;
    logic [N-1:0] res;
    logic         c_flag;
    logic         v_flag;
    logic [3:0]   flg;

    // S2 can take a new beat when it is empty or being drained this cycle.
    assign adv2     = s1_valid & (~out_valid | out_ready);
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= A;
                s1_b  <= B;
                s1_op <= op_t'(OP);
            end
        end
    end

`ifdef ALU_ACC_EN
    logic [N-1:0] acc;
    logic         s1_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_acc <= 1'b0;
        end else if (adv1 && in_valid) begin
            s1_acc <= in_acc;
        end
    end

    // The accumulator tracks every retired result, so a dependent beat sitting
    // in S1 always sees its predecessor's result at the moment it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (adv2) begin
            acc <= res;
        end
    end

    assign bop = s1_acc ? acc : s1_b;
`else
    logic unused_in_acc;
    assign unused_in_acc = in_acc;
    assign bop           = s1_b;
`endif

    assign sum = {1'b0, s1_a} + {1'b0, bop};
    assign dif = {1'b0, s1_a} + {1'b0, ~bop} + {{N{1'b0}}, 1'b1};
    assign lt  = $signed(s1_a) < $signed(bop);

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (s1_op)
            OP_AND:  res = s1_a & bop;
            OP_OR:   res = s1_a | bop;
            OP_XOR:  res = s1_a ^ bop;
            OP_NOR:  res = ~(s1_a | bop);
            OP_ADD: begin
                res    = sum[N-1:0];
                c_flag = sum[N];
                v_flag = (s1_a[N-1] == bop[N-1]) && (sum[N-1] != s1_a[N-1]);
            end
            OP_SUB: begin
                res    = dif[N-1:0];
                c_flag = dif[N];
                v_flag = (s1_a[N-1] != bop[N-1]) && (dif[N-1] != s1_a[N-1]);
            end
            OP_SLT:  res = {{(N-1){1'b0}}, lt};
            OP_PASS: res = s1_a;
            default: res = '0;
        endcase
        flg = {(res == '0), res[N-1], c_flag, v_flag};
    end

    // Without adv2, out_ready can only be high here when S1 is empty, so the
    // output slot simply drains and Y/FLAGS keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Y         <= '0;
            FLAGS     <= '0;
        end else if (adv2) begin
            out_valid <= 1'b1;
            Y         <= res;
            FLAGS     <= flg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_p.sv
// Directed bench for alu_pipe_p (N=4): arithmetic model + scoreboard queue,
// literal expectations pin the model; honours ALU_ACC_EN like the design.
module tb_alu_pipe_p;
    localparam int N = 4;
    localparam int W = 1 << N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   OP;
    logic         in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Y;
    logic [3:0]   FLAGS;

    alu_pipe_p #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .OP(OP), .in_acc(in_acc), .out_valid(out_valid),
        .out_ready(out_ready), .Y(Y), .FLAGS(FLAGS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y;
        int f;
        int ly;
        int lf;
        int t;
        bit lchk;
        bit seen;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;
    int model_acc = 0;
    int lit_y = -1;
    int lit_f = -1;
    bit lat_chk = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Result and {Z,N,C,V} from plain integer arithmetic.
    function automatic void model(input int a, input int b, input int op,
                                  output int y, output int f);
        int sa, sb, r, c, v;
        sa = (a >= W/2) ? a - W : a;
        sb = (b >= W/2) ? b - W : b;
        c = 0; v = 0; y = 0;
        case (op)
            0: y = a & b;
            1: y = a | b;
            2: y = a ^ b;
            3: y = (W - 1) - (a | b);
            4: begin
                r = a + b; y = r % W; c = (r >= W);
                v = (sa + sb > W/2 - 1) || (sa + sb < -W/2);
            end
            5: begin
                y = (a - b + W) % W; c = (a >= b);
                v = (sa - sb > W/2 - 1) || (sa - sb < -W/2);
            end
            6: y = (sa < sb) ? 1 : 0;
            default: y = a;
        endcase
        f = ((y == 0) ? 8 : 0) + ((y >= W/2) ? 4 : 0) + c * 2 + v;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    check("y_model", int'(Y), q[0].y);
                    check("flags_model", int'(FLAGS), q[0].f);
                    if (q[0].ly >= 0) check("y_literal", int'(Y), q[0].ly);
                    if (q[0].lf >= 0) check("flags_literal", int'(FLAGS), q[0].lf);
                    if (q[0].lchk && !q[0].seen) check("latency", cyc - q[0].t, 2);
                    q[0].seen = 1'b1;
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                beat_t e;
                int bop, y, f;
`ifdef ALU_ACC_EN
                bop = in_acc ? model_acc : int'(B);
`else
                bop = int'(B);
`endif
                model(int'(A), bop, int'(OP), y, f);
                model_acc = y;
                e.y = y; e.f = f; e.ly = lit_y; e.lf = lit_f;
                e.t = cyc; e.lchk = lat_chk; e.seen = 1'b0;
                q.push_back(e);
                accepts++;
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the beat was accepted.
    task automatic send(input int a, input int b, input int op, input bit acc,
                        input int ly, input int lf);
        int t;
        in_valid = 1'b1; A = a[N-1:0]; B = b[N-1:0]; OP = op[2:0]; in_acc = acc;
        lit_y = ly; lit_f = lf;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        lit_y = -1; lit_f = -1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("drain_empty", q.size(), 0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        model_acc = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y", int'(Y), 0);
        check("rst_flags", int'(FLAGS), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int a0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = '0; in_acc = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        assert_reset();

        // Logic ops back-to-back
        send(12, 10, 0, 0, 8'h8, 4'b0100);
        send(12, 10, 1, 0, 8'hE, 4'b0100);
        send(12, 10, 2, 0, 8'h6, 4'b0000);
        send(12, 10, 3, 0, 8'h1, 4'b0000);
        // Arithmetic, compare, pass
        send(7, 1, 4, 0, 8'h8, 4'b0101);
        send(15, 1, 4, 0, 8'h0, 4'b1010);
        send(3, 5, 5, 0, 8'hE, 4'b0100);
        send(5, 3, 5, 0, 8'h2, 4'b0010);
        send(8, 1, 6, 0, 1, 4'b0000);
        send(1, 8, 6, 0, 0, 4'b1000);
        send(8, 8, 5, 0, 0, 4'b1010);
        send(9, 2, 7, 0, 9, 4'b0100);
        drain();

        // Backpressure: output stalled for 5 cycles
        lat_chk = 1'b0;
        out_ready = 1'b0;
        a0 = accepts;
        fork
            begin
                send(1, 2, 4, 0, 3, 4'b0000);
                send(3, 4, 4, 0, 7, 4'b0000);
                send(5, 6, 4, 0, 11, 4'b0101);
                send(9, 9, 4, 0, 2, 4'b0011);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_accepts", accepts - a0, 2);
                check("stall_out_valid", int'(out_valid), 1);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_total_accepts", accepts - a0, 4);
        lat_chk = 1'b1;

        // Reset with two beats in flight
        out_ready = 1'b0;
        lat_chk = 1'b0;
        send(3, 4, 4, 0, 7, -1);
        send(15, 15, 0, 0, 15, -1);
        check("pre_reset_out_valid", int'(out_valid), 1);
        assert_reset();
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(5, 0, 7, 0, 5, 4'b0000);
        send(3, 5, 2, 0, 6, 4'b0000);
        drain();

        // Accumulator chaining from reset
        assert_reset();
`ifdef ALU_ACC_EN
        send(1, 0, 4, 1, 1, 4'b0000);
        send(1, 0, 4, 1, 2, 4'b0000);
        send(1, 0, 4, 1, 3, 4'b0000);
`else
        send(1, 0, 4, 1, 1, 4'b0000);
        send(1, 0, 4, 1, 1, 4'b0000);
        send(1, 0, 4, 1, 1, 4'b0000);
`endif
        drain();
        repeat (3) @(posedge clk);
        #2;
        check("idle_out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
